// File: rtl/fifo_byte_assembler_pkg.sv
// Package for fifo_byte_assembler: assembler state encoding, default geometry,
// and the helper that sizes the out_bytes field.
// Used with the optional ASM_CHECKSUM_EN build (see fifo_byte_assembler.sv).
package fifo_asm_pkg;

  localparam int unsigned DEF_WIDTH          = 8;
  localparam int unsigned DEF_BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    StFill,
    StDrain,
    StHold
  } asm_state_e;

  // out_bytes must be able to hold BYTES_PER_WORD itself, hence the +1.
  function automatic int unsigned out_bytes_width(input int unsigned bytes_per_word);
    return $clog2(bytes_per_word) + 1;
  endfunction

endpackage

// File: rtl/fifo_byte_assembler_if.sv
// Bundle between the byte assembler, the async FIFO read port and the word sink.
//   fifo_empty / fifo_rd_en / fifo_rd_data : FIFO read side (data registered, valid
//                                             the cycle after an accepted read)
//   flush                                  : single-cycle request to emit a partial word
//   out_valid / out_ready                  : word handshake
//   out_data / out_bytes                   : packed word (byte 0 in LSBs), valid byte count
//   out_csum                               : XOR of valid bytes, present only with ASM_CHECKSUM_EN
// Modport master is the assembler side; slave is the FIFO/sink environment.
interface fifo_byte_assembler_if #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BYTES_PER_WORD = 4
);
  import fifo_asm_pkg::*;

  localparam int unsigned BytesW = out_bytes_width(BYTES_PER_WORD);

  logic                              fifo_empty;
  logic                              fifo_rd_en;
  logic [WIDTH-1:0]                  fifo_rd_data;
  logic                              flush;
  logic                              out_valid;
  logic                              out_ready;
  logic [WIDTH*BYTES_PER_WORD-1:0]   out_data;
  logic [BytesW-1:0]                 out_bytes;
`ifdef ASM_CHECKSUM_EN
  logic [WIDTH-1:0]                  out_csum;
`endif

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    input  flush,
    input  out_ready,
    output fifo_rd_en,
    output out_valid,
    output out_data,
`ifdef ASM_CHECKSUM_EN
    output out_csum,
`endif
    output out_bytes
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    output flush,
    output out_ready,
    input  fifo_rd_en,
    input  out_valid,
    input  out_data,
`ifdef ASM_CHECKSUM_EN
    input  out_csum,
`endif
    input  out_bytes
  );

endinterface

// File: rtl/fifo_byte_assembler.sv
// fifo_byte_assembler: read-side consumer of the async FIFO, in the FIFO read clock domain.
// Drains bytes through fifo_rd_en/fifo_empty, packs them little-endian into
// BYTES_PER_WORD-byte words and offers each word on out_valid/out_ready.
// A flush pulse emits the current partial word (after any in-flight byte lands).
// Ports:
//   rd_clk  : FIFO read clock
//   rd_rst  : asynchronous active-high reset
//   bus     : fifo_byte_assembler_if.master (FIFO read port, flush, word output)
// Build option: define ASM_CHECKSUM_EN to add bus.out_csum, the XOR of the valid bytes.
module fifo_byte_assembler
  import fifo_asm_pkg::*;
#(
  parameter int unsigned WIDTH          = DEF_WIDTH,
  parameter int unsigned BYTES_PER_WORD = DEF_BYTES_PER_WORD
) (
  input logic                   rd_clk,
  input logic                   rd_rst,
  fifo_byte_assembler_if.master bus
);

  localparam int unsigned     CntW    = out_bytes_width(BYTES_PER_WORD);
  localparam logic [CntW-1:0] FullCnt = CntW'(BYTES_PER_WORD);
  localparam logic [CntW:0]   FullLvl = (CntW + 1)'(BYTES_PER_WORD);

  asm_state_e       state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             pending_q, pending_d;
  logic [WIDTH-1:0] lanes_q [BYTES_PER_WORD];
  logic [WIDTH-1:0] lanes_d [BYTES_PER_WORD];

  logic [CntW:0]                   fill_level;
  logic [CntW-1:0]                 count_inc;
  logic                            rd_en;
  logic                            hold;
  logic [WIDTH*BYTES_PER_WORD-1:0] word;

  // Bytes already captured plus the one in flight; reads stop once a word is covered.
  assign fill_level = {1'b0, count_q} + {{CntW{1'b0}}, pending_q};
  assign count_inc  = count_q + CntW'(1);
  assign hold       = (state_q == StHold);

  assign rd_en = !rd_rst && (state_q == StFill) && !bus.fifo_empty &&
                 (fill_level < FullLvl) && !bus.flush;

  assign pending_d = rd_en;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lanes_d = lanes_q;

    // The byte read last cycle is on fifo_rd_data now; it lands in lane count_q.
    if (pending_q) begin
      count_d = count_inc;
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        if (count_q == CntW'(i)) lanes_d[i] = bus.fifo_rd_data;
      end
    end

    unique case (state_q)
      StFill: begin
        // A completing capture wins over a simultaneous flush.
        if (pending_q && (count_inc == FullCnt)) begin
          state_d = StHold;
        end else if (bus.flush) begin
          if (pending_q) begin
            state_d = StDrain;
          end else if (count_q != '0) begin
            state_d = StHold;
          end
        end
      end
      StDrain: state_d = StHold;
      StHold: begin
        if (bus.out_ready) begin
          state_d = StFill;
          count_d = '0;
          for (int i = 0; i < BYTES_PER_WORD; i++) lanes_d[i] = '0;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q   <= StFill;
      count_q   <= '0;
      pending_q <= 1'b0;
      for (int i = 0; i < BYTES_PER_WORD; i++) lanes_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      for (int i = 0; i < BYTES_PER_WORD; i++) lanes_q[i] <= lanes_d[i];
    end
  end

  // Outputs read as zero outside HOLD so unused lanes never leak partial data.
  always_comb begin
    word = '0;
    if (hold) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) word[i*WIDTH +: WIDTH] = lanes_q[i];
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_valid  = hold;
  assign bus.out_data   = word;
  assign bus.out_bytes  = hold ? count_q : '0;

`ifdef ASM_CHECKSUM_EN
  logic [WIDTH-1:0] csum;

  // Lanes past count are zero, so XOR over all lanes equals XOR over valid bytes.
  always_comb begin
    csum = '0;
    if (hold) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) csum = csum ^ lanes_q[i];
    end
  end

  assign bus.out_csum = csum;
`endif

endmodule

// File: tb/tb_fifo_byte_assembler.sv
// Directed bench for fifo_byte_assembler (WIDTH=8, BYTES_PER_WORD=4).
// A byte queue stands in for the FIFO: an accepted read pops the queue and the byte
// appears on fifo_rd_data just after the clock edge, i.e. registered read data.
module tb_fifo_byte_assembler;

  logic rd_clk;
  logic rd_rst;
  int   n_checks;
  int   n_err;
  logic [7:0] fq[$];

  fifo_byte_assembler_if #(.WIDTH(8), .BYTES_PER_WORD(4)) bus ();

  fifo_byte_assembler #(.WIDTH(8), .BYTES_PER_WORD(4)) dut (
    .rd_clk (rd_clk),
    .rd_rst (rd_rst),
    .bus    (bus)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; returns 1 ns after the rising edge.
  task automatic tick();
    logic rd;
    @(negedge rd_clk);
    rd = bus.fifo_rd_en && !bus.fifo_empty;
    @(posedge rd_clk);
    #1;
    if (rd && fq.size() != 0) bus.fifo_rd_data = fq.pop_front();
    bus.fifo_empty = (fq.size() == 0);
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    bus.fifo_empty = 1'b0;
  endtask

  // Called in the cycle of the first read; expects the word exp_cycle cycles later.
  task automatic wait_word(input string tag, input logic [31:0] exp_data,
                           input logic [2:0] exp_bytes, input int exp_cycle);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 16) begin
      tick();
      cyc++;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    check({tag, "_seen"}, 64'(seen), 64'd1);
    check({tag, "_cycle"}, 64'(cyc), 64'(exp_cycle));
    check({tag, "_data"}, 64'(bus.out_data), 64'(exp_data));
    check({tag, "_bytes"}, 64'(bus.out_bytes), 64'(exp_bytes));
  endtask

  initial begin
    bit stable;
    n_checks = 0;
    n_err    = 0;
    rd_rst           = 1'b0;
    bus.fifo_empty   = 1'b1;
    bus.fifo_rd_data = 8'h00;
    bus.flush        = 1'b0;
    bus.out_ready    = 1'b0;

    // Reset state, with a byte waiting so rd_en gating by reset is visible.
    #2 rd_rst = 1'b1;
    push(8'h55);
    #1;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_data", 64'(bus.out_data), 64'd0);
    check("rst_bytes", 64'(bus.out_bytes), 64'd0);
    check("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
`ifdef ASM_CHECKSUM_EN
    check("rst_csum", 64'(bus.out_csum), 64'd0);
`endif
    fq.delete();
    bus.fifo_empty = 1'b1;
    tick();
    tick();
    rd_rst = 1'b0;
    tick();

    // Full word with out_ready held high.
    bus.out_ready = 1'b1;
    push(8'hCC); push(8'hAA); push(8'h11); push(8'h22);
    #1;
    check("w1_rd_en", 64'(bus.fifo_rd_en), 64'd1);
    wait_word("w1", 32'h2211AACC, 3'd4, 5);
    tick();
    check("w1_one_cycle", 64'(bus.out_valid), 64'd0);

    // Back-pressure: first word held 10 cycles, no reads meanwhile.
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_word("w2a", 32'h04030201, 3'd4, 5);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h04030201 ||
          bus.out_bytes !== 3'd4 || bus.fifo_rd_en !== 1'b0) stable = 1'b0;
    end
    check("w2_hold_stable", 64'(stable), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    check("w2_rd_after_hs", 64'(bus.fifo_rd_en), 64'd1);
    check("w2_valid_after_hs", 64'(bus.out_valid), 64'd0);
    wait_word("w2b", 32'h08070605, 3'd4, 5);
    tick();

    // Partial word: two bytes, FIFO runs dry, then flush.
    push(8'hCC); push(8'hAA);
    for (int i = 0; i < 4; i++) tick();
    check("p_no_valid", 64'(bus.out_valid), 64'd0);
    check("p_no_rd", 64'(bus.fifo_rd_en), 64'd0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("p_valid", 64'(bus.out_valid), 64'd1);
    check("p_data", 64'(bus.out_data), 64'h0000AACC);
    check("p_bytes", 64'(bus.out_bytes), 64'd2);
`ifdef ASM_CHECKSUM_EN
    check("p_csum", 64'(bus.out_csum), 64'h66);
`endif
    tick();
    check("p_released", 64'(bus.out_valid), 64'd0);

    // Flush right after the second accepted read: DRAIN, then a 2-byte word.
    push(8'h31); push(8'h32); push(8'h33);
    tick();
    tick();
    bus.flush = 1'b1;
    #1;
    check("d_rd_blocked", 64'(bus.fifo_rd_en), 64'd0);
    tick();
    bus.flush = 1'b0;
    #1;
    check("d_drain_valid", 64'(bus.out_valid), 64'd0);
    check("d_drain_rd", 64'(bus.fifo_rd_en), 64'd0);
    tick();
    check("d_valid", 64'(bus.out_valid), 64'd1);
    check("d_data", 64'(bus.out_data), 64'h00003231);
    check("d_bytes", 64'(bus.out_bytes), 64'd2);
    tick();
    tick();
    tick();
    // One byte captured, nothing in flight: flush goes straight to HOLD.
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("s_valid", 64'(bus.out_valid), 64'd1);
    check("s_data", 64'(bus.out_data), 64'h00000033);
    check("s_bytes", 64'(bus.out_bytes), 64'd1);
    tick();

    // Reset with three bytes captured and the fourth in flight.
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    for (int i = 0; i < 4; i++) tick();
    #1 rd_rst = 1'b1;
    #1;
    check("r_valid", 64'(bus.out_valid), 64'd0);
    check("r_data", 64'(bus.out_data), 64'd0);
    check("r_bytes", 64'(bus.out_bytes), 64'd0);
    check("r_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    tick();
    rd_rst = 1'b0;
    push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
    wait_word("r_clean", 32'hB4B3B2B1, 3'd4, 5);
    tick();

    // Flush with nothing collected and the FIFO empty is ignored.
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (bus.out_valid !== 1'b0 || bus.fifo_rd_en !== 1'b0) stable = 1'b0;
      tick();
    end
    check("e_ignored", 64'(stable), 64'd1);
    push(8'h5A); push(8'h5B); push(8'h5C); push(8'h5D);
    wait_word("e_after", 32'h5D5C5B5A, 3'd4, 5);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
